// File: rtl/bft_stream_packetizer.sv
// Stream-to-BFT packetizer: wraps vld/ack words into addressed 49-bit packets under credit flow control.
// Define PKT_COUNT_EN to add a transfer counter (pkt_count) with synchronous clear (pkt_count_clr).
module bft_stream_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int SELF_LEAF     = 1,
    parameter int MAX_CREDIT    = 128
) (
    input  logic                     clk_400,
    input  logic                     resetn_400,
    input  logic                     start,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user2packetizer,
    input  logic                     vld_user2packetizer,
    output logic                     ack_packetizer2user,
    input  logic [PACKET_BITS-1:0]   din_bft2packetizer,
    output logic [PACKET_BITS-1:0]   dout_packetizer2bft,
    input  logic                     resend,
    output logic [7:0]               credit,
`ifdef PKT_COUNT_EN
    input  logic                     pkt_count_clr,
    output logic [31:0]              pkt_count,
`endif
    output logic                     busy
);

    localparam int ADDR_LSB = PAYLOAD_BITS;
    localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
    localparam logic [NUM_LEAF_BITS-1:0] SELF_LEAF_L  = NUM_LEAF_BITS'(SELF_LEAF);
    localparam logic [8:0]               MAX_CREDIT_W = 9'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        WAIT_CREDIT = 2'd2
    } state_t;

    state_t                   state_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [7:0]               credit_q;
    logic [7:0]               credit_d;
    logic [PACKET_BITS-1:0]   dout_q;
    logic                     busy_q;
    logic                     upd;
    logic [7:0]               inc;
    logic                     xfer;
    logic [8:0]               credit_sum;
    logic                     unused_din_bits;

    // Clamp the 9-bit credit sum to the destination buffer depth.
    function automatic logic [7:0] sat_credit(input logic [8:0] sum);
        if (sum > MAX_CREDIT_W) begin
            return MAX_CREDIT_W[7:0];
        end
        return sum[7:0];
    endfunction

    assign upd = din_bft2packetizer[PACKET_BITS-1]
              && (din_bft2packetizer[LEAF_LSB +: NUM_LEAF_BITS] == SELF_LEAF_L)
              && (din_bft2packetizer[PORT_LSB +: NUM_PORT_BITS] == '0);
    assign inc = upd ? din_bft2packetizer[7:0] : 8'd0;

    assign unused_din_bits = ^{din_bft2packetizer[ADDR_LSB +: NUM_ADDR_BITS],
                               din_bft2packetizer[PAYLOAD_BITS-1:8]};

    assign ack_packetizer2user = (state_q == RUN) && vld_user2packetizer
                              && (credit_q != 8'd0) && !resend;
    assign xfer = vld_user2packetizer && ack_packetizer2user;

    assign credit_sum = {1'b0, credit_q} - 9'(xfer) + {1'b0, inc};
    assign credit_d   = sat_credit(credit_sum);

    always_ff @(posedge clk_400) begin
        if (!resetn_400) begin
            state_q  <= IDLE;
            leaf_q   <= '0;
            port_q   <= '0;
            addr_q   <= '0;
            credit_q <= MAX_CREDIT_W[7:0];
            dout_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            credit_q <= credit_d;
            dout_q   <= xfer ? {1'b1, leaf_q, port_q, addr_q, din_user2packetizer} : '0;
            if (xfer) begin
                addr_q <= addr_q + NUM_ADDR_BITS'(1);
            end
            // resend freezes the control state; credit updates above still land.
            if (!resend) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            leaf_q  <= dest_leaf;
                            port_q  <= dest_port;
                            addr_q  <= '0;
                        end
                    end
                    RUN: begin
                        if (xfer && (credit_q == 8'd1) && !upd) begin
                            state_q <= WAIT_CREDIT;
                        end
                    end
                    WAIT_CREDIT: begin
                        if (credit_q != 8'd0) begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef PKT_COUNT_EN
    logic [31:0] pkt_count_q;

    always_ff @(posedge clk_400) begin
        if (!resetn_400 || pkt_count_clr) begin
            pkt_count_q <= '0;
        end else if (xfer) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

    assign dout_packetizer2bft = resend ? '0 : dout_q;
    assign credit              = credit_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Randomized and directed bench for bft_stream_packetizer against a behavioural reference model.
module tb_bft_stream_packetizer;

    localparam int SELF_LEAF  = 1;
    localparam int MAX_CREDIT = 128;

    logic        clk_400;
    logic        resetn_400;
    logic        start;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [31:0] din_user;
    logic        vld;
    logic        ack;
    logic [48:0] din_bft;
    logic [48:0] dout;
    logic        resend;
    logic [7:0]  credit;
    logic        busy;
`ifdef PKT_COUNT_EN
    logic        pkt_count_clr;
    logic [31:0] pkt_count;
    int unsigned m_cnt;
`endif

    int n_tests;
    int n_fail;

    // Reference model state, in plain terms of the behaviour.
    bit          m_running;
    bit          m_waiting;
    int          m_credit;
    int          m_addr;
    bit [4:0]    m_leaf;
    bit [3:0]    m_port;
    bit [48:0]   m_dout;

    bft_stream_packetizer dut (
        .clk_400             (clk_400),
        .resetn_400          (resetn_400),
        .start               (start),
        .dest_leaf           (dest_leaf),
        .dest_port           (dest_port),
        .din_user2packetizer (din_user),
        .vld_user2packetizer (vld),
        .ack_packetizer2user (ack),
        .din_bft2packetizer  (din_bft),
        .dout_packetizer2bft (dout),
        .resend              (resend),
        .credit              (credit),
`ifdef PKT_COUNT_EN
        .pkt_count_clr       (pkt_count_clr),
        .pkt_count           (pkt_count),
`endif
        .busy                (busy)
    );

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] mk_upd(input logic [4:0] leaf, input logic [3:0] port,
                                           input logic [7:0] amount);
        return {1'b1, leaf, port, 7'd0, 24'd0, amount};
    endfunction

    function automatic bit model_ack();
        return m_running && !m_waiting && vld && (m_credit > 0) && !resend;
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_waiting = 1'b0;
        m_credit  = MAX_CREDIT;
        m_addr    = 0;
        m_leaf    = '0;
        m_port    = '0;
        m_dout    = '0;
`ifdef PKT_COUNT_EN
        m_cnt     = 0;
`endif
    endtask

    task automatic model_edge();
        bit sent;
        bit is_upd;
        int amount;
        sent = model_ack();
        if (!resetn_400) begin
            model_reset();
            return;
        end
        is_upd = din_bft[48] && (din_bft[47:43] == 5'(SELF_LEAF)) && (din_bft[42:39] == 4'd0);
        amount = is_upd ? int'(din_bft[7:0]) : 0;
        m_dout = sent ? {1'b1, m_leaf, m_port, 7'(m_addr), din_user} : 49'd0;
        if (!resend) begin
            if (!m_running) begin
                if (start) begin
                    m_running = 1'b1;
                    m_leaf    = dest_leaf;
                    m_port    = dest_port;
                    m_addr    = 0;
                end
            end else if (m_waiting) begin
                if (m_credit != 0) m_waiting = 1'b0;
            end else if (sent && m_credit == 1 && !is_upd) begin
                m_waiting = 1'b1;
            end
        end
        if (sent) m_addr = (m_addr + 1) % 128;
        m_credit = m_credit - int'(sent) + amount;
        if (m_credit > MAX_CREDIT) m_credit = MAX_CREDIT;
`ifdef PKT_COUNT_EN
        if (pkt_count_clr) m_cnt = 0;
        else if (sent) m_cnt = m_cnt + 1;
`endif
    endtask

    // Called at a negedge with inputs already driven: check outputs, then advance one clock.
    task automatic cycle();
        #1;
        check_eq("ack", 64'(ack), 64'(model_ack()));
        check_eq("dout", 64'(dout), resend ? 64'd0 : 64'(m_dout));
        check_eq("credit", 64'(credit), 64'(m_credit));
        check_eq("busy", 64'(busy), 64'(m_running));
`ifdef PKT_COUNT_EN
        check_eq("pkt_count", 64'(pkt_count), 64'(m_cnt));
`endif
        @(posedge clk_400);
        model_edge();
        @(negedge clk_400);
    endtask

    initial begin
        int acks;
        int guard;
        int saved;
        int exp_addr;
        n_tests    = 0;
        n_fail     = 0;
        resetn_400 = 1'b0;
        start      = 1'b0;
        dest_leaf  = '0;
        dest_port  = '0;
        din_user   = '0;
        vld        = 1'b0;
        din_bft    = '0;
        resend     = 1'b0;
`ifdef PKT_COUNT_EN
        pkt_count_clr = 1'b0;
`endif
        repeat (2) @(posedge clk_400);
        @(negedge clk_400);
        model_reset();

        // Reset state, with vld high to show ack stays low in IDLE.
        vld = 1'b1;
        cycle();
        #1;
        check_eq("rst_credit", 64'(credit), 64'd128);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_ack", 64'(ack), 64'd0);
        @(negedge clk_400);

        // Basic send.
        resetn_400 = 1'b1;
        vld        = 1'b0;
        start      = 1'b1;
        dest_leaf  = 5'd3;
        dest_port  = 4'd2;
        cycle();
        start    = 1'b0;
        vld      = 1'b1;
        din_user = 32'hDEADBEEF;
        cycle();
        vld = 1'b0;
        check_eq("basic_dout", 64'(dout), 64'h1_1900_DEADBEEF);
        check_eq("basic_credit", 64'(credit), 64'd127);

        // Credit exhaustion from a fresh reset.
        resetn_400 = 1'b0;
        cycle();
        resetn_400 = 1'b1;
        start      = 1'b1;
        dest_leaf  = 5'd5;
        dest_port  = 4'd7;
        cycle();
        start = 1'b0;
        acks  = 0;
        for (int i = 0; i < 130; i++) begin
            vld      = 1'b1;
            din_user = $urandom;
            #1;
            if (ack) acks++;
            cycle();
        end
        check_eq("exh_acks", 64'(acks), 64'd128);
        check_eq("exh_ack_low", 64'(ack), 64'd0);
        check_eq("exh_credit", 64'(credit), 64'd0);
        check_eq("exh_busy", 64'(busy), 64'd1);

        // Credit return: credit visible next cycle, ack the cycle after.
        din_bft = mk_upd(5'(SELF_LEAF), 4'd0, 8'd64);
        cycle();
        din_bft = '0;
        check_eq("ret_credit", 64'(credit), 64'd64);
        check_eq("ret_wait_ack", 64'(ack), 64'd0);
        cycle();
        check_eq("ret_ack", 64'(ack), 64'd1);
        din_user = 32'h0BAD_F00D;
        cycle();
        vld = 1'b0;
        check_eq("wrap_addr", 64'(dout[38:32]), 64'd0);
        saved   = m_credit;
        din_bft = mk_upd(5'd7, 4'd0, 8'd50);
        cycle();
        check_eq("wrong_leaf", 64'(credit), 64'(saved));
        din_bft = mk_upd(5'(SELF_LEAF), 4'd3, 8'd50);
        cycle();
        check_eq("nonzero_port", 64'(credit), 64'(saved));
        din_bft = '0;

        // Drain to 10, then simultaneous transfer + update, then saturation.
        guard = 0;
        while (m_credit != 10 && guard < 200) begin
            vld      = 1'b1;
            din_user = $urandom;
            cycle();
            guard++;
        end
        vld = 1'b0;
        check_eq("drain_bound", 64'(guard < 200), 64'd1);
        vld     = 1'b1;
        din_bft = mk_upd(5'(SELF_LEAF), 4'd0, 8'd5);
        cycle();
        vld = 1'b0;
        check_eq("simul", 64'(credit), 64'd14);
        din_bft = mk_upd(5'(SELF_LEAF), 4'd0, 8'd86);
        cycle();
        check_eq("reach_100", 64'(credit), 64'd100);
        din_bft = mk_upd(5'(SELF_LEAF), 4'd0, 8'd200);
        cycle();
        din_bft = '0;
        check_eq("saturate", 64'(credit), 64'd128);

        // resend mid-stream.
        for (int i = 0; i < 3; i++) begin
            vld      = 1'b1;
            din_user = $urandom;
            cycle();
        end
        exp_addr = m_addr;
        for (int i = 0; i < 4; i++) begin
            resend = 1'b1;
            #1;
            check_eq("resend_ack", 64'(ack), 64'd0);
            check_eq("resend_dout", 64'(dout), 64'd0);
            cycle();
        end
        resend = 1'b0;
        cycle();
        vld = 1'b0;
        check_eq("resend_addr", 64'(dout[38:32]), 64'(exp_addr));

        // Reset in the middle of a transfer.
        vld = 1'b1;
        cycle();
        resetn_400 = 1'b0;
        cycle();
        resetn_400 = 1'b1;
        check_eq("midrst_dout", 64'(dout), 64'd0);
        check_eq("midrst_credit", 64'(credit), 64'd128);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("no_ack_before_start", 64'(ack), 64'd0);
            cycle();
        end
        vld       = 1'b0;
        start     = 1'b1;
        dest_leaf = 5'd9;
        dest_port = 4'd4;
        cycle();
        start = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn_400 = ($urandom_range(0, 499) != 0);
            start      = ($urandom_range(0, 19) == 0);
            dest_leaf  = 5'($urandom);
            dest_port  = 4'($urandom_range(1, 15));
            vld        = ($urandom_range(0, 3) != 0);
            din_user   = $urandom;
            resend     = ($urandom_range(0, 9) == 0);
`ifdef PKT_COUNT_EN
            pkt_count_clr = ($urandom_range(0, 99) == 0);
`endif
            if ($urandom_range(0, 3) == 0) begin
                din_bft = {1'b1,
                           ($urandom_range(0, 2) != 0) ? 5'(SELF_LEAF) : 5'($urandom),
                           ($urandom_range(0, 4) != 0) ? 4'd0 : 4'($urandom),
                           7'($urandom), 24'($urandom), 8'($urandom_range(0, 6))};
            end else begin
                din_bft = {1'b0, 48'($urandom)};
            end
            cycle();
        end

        resetn_400 = 1'b1;
        start      = 1'b0;
        vld        = 1'b0;
        resend     = 1'b0;
        din_bft    = '0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bft_stream_packetizer.md
Name: bft_stream_packetizer

Overview:
- Source-side counterpart of the leaf interface's BFT receive path.
- Accepts 32-bit words from a user/host stream (vld/ack handshake) and emits 49-bit BFT packets addressed to one destination leaf/port.
- Enforces credit-based flow control using free-space update packets returned over the BFT.
- Used by the host/DMA-side endpoint and as a traffic generator for leaf verification; runs in the 400 MHz BFT domain.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, data payload width.
- NUM_LEAF_BITS, 5, leaf address field width.
- NUM_PORT_BITS, 4, port field width.
- NUM_ADDR_BITS, 7, write-address field width; wraps modulo 2^7.
- SELF_LEAF, 1, this endpoint's leaf address; credit updates must target it.
- MAX_CREDIT, 128, initial and maximum credit in words (destination BRAM depth).

Ports:
- clk_400  in  1  clock.
- resetn_400  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches dest_leaf/dest_port, leaves IDLE.
- dest_leaf  in  5  destination leaf, sampled on start.
- dest_port  in  4  destination input port (1..15; 0 reserved for control), sampled on start.
- din_user2packetizer  in  32  stream data.
- vld_user2packetizer  in  1  stream data valid.
- ack_packetizer2user  out  1  word accepted this cycle.
- din_bft2packetizer  in  49  packets from BFT (credit updates).
- dout_packetizer2bft  out  49  packets to BFT.
- resend  in  1  BFT resend request; suspends transmission.
- credit  out  8  current credit count.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset is synchronous, active-low; all state is cleared on the clk_400 edge with resetn_400=0.
- Reset values:
  - dout=0, ack=0, busy=0.
  - credit=MAX_CREDIT, addr counter=0, state=IDLE.
  - latched dest=0.
- Packet format, MSB to LSB:
  - [48] valid
  - [47:43] leaf
  - [42:39] port
  - [38:32] addr
  - [31:0] payload
- States:
  - IDLE: ack=0. On start → RUN; latch dest_leaf/dest_port; addr←0. Credit is not reset by start.
  - RUN: ack = vld & (credit≠0) & ~resend, combinational. If a transfer occurs while credit==1 and no update arrives the same cycle → WAIT_CREDIT.
  - WAIT_CREDIT: ack=0. When credit becomes nonzero → RUN.
- No return to IDLE except by reset. start is ignored outside IDLE.
- Transfer: a word is accepted in a cycle where vld & ack. On the next edge:
  - dout ← {1, dest_leaf, dest_port, addr, data}.
  - addr ← addr+1, wrapping 127→0.
  - credit decrements.
- dout is registered, so latency is 1 cycle from acceptance to packet. In any cycle without a transfer, dout ← 0 on the next edge.
- Credit update packet: din[48]=1, din[47:43]=SELF_LEAF, din[42:39]=0. Increment = din[7:0].
  - credit ← min(credit − sent + inc, MAX_CREDIT), where sent ∈ {0,1}.
  - Arithmetic uses 9-bit intermediate, no wrap.
  - Simultaneous transfer and update are both applied in the same cycle.
- Packets with a different leaf or a nonzero port are ignored. An update arriving in IDLE is applied.
- resend=1: ack forced 0. dout is also forced to 0 combinationally at the output while resend=1. Credit updates still apply; state and addr are held.
- Reset mid-stream: the next edge returns everything to reset values. An in-flight dout word is dropped.

Optional Feature:
- Macro PKT_COUNT_EN.
- Defined:
  - adds output pkt_count [31:0], reset 0, incremented on each transfer, wrapping 0xFFFFFFFF→0.
  - adds input pkt_count_clr (synchronous clear). Clear takes priority over increment in the same cycle.
- Undefined: no such ports and no counter logic.

Test Plan:
- Basic send: reset, start with dest_leaf=3, dest_port=2, send 0xDEADBEEF → next cycle dout=0x1_1900_DEADBEEF (valid=1, leaf=3, port=2, addr=0); credit=127.
- Credit exhaustion: stream 130 words with continuous vld, no updates → exactly 128 acks; ack=0 afterwards; state WAIT_CREDIT; credit=0; addr wrapped to 0.
- Credit return: in WAIT_CREDIT, inject update with leaf=SELF_LEAF, port=0, inc=64 → credit=64 next cycle; ack resumes the following cycle. Inject update to leaf≠SELF_LEAF → credit unchanged.
- Simultaneous events: credit=10, a transfer coincides with update inc=5 → credit=14. Update inc=200 at credit=100 → credit=128 (saturates).
- resend: assert resend for 4 cycles mid-stream → ack=0 and dout=0 for those cycles; next word after deassert carries the consecutive addr (no gap, no duplicate).
- Reset mid-stream: resetn_400=0 for 1 cycle during a transfer → next cycle dout=0, credit=128, busy=0; start needed before ack returns.
